fetch_sequencer: RTL

- Control FSM that sequences the program counter through fetch/execute: drives PC increment, PC load on taken branch, MAR load, memory read, IR load, and the execute-start handshake.
- Sits between the PC/MAR/MDR/IR datapath registers and the execution control unit.
- Handles memory-ready wait with a timeout, halt requests at instruction boundaries, and a retired-instruction counter.

---
 rtl/fetch_sequencer_pkg.sv | 13 +
 rtl/fetch_sequencer_mem_wait_timer.sv | 18 +
 rtl/fetch_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: state encodings and default parameters shared by the fetch sequencer.
package fetch_sequencer_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_IR     = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;
  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int COUNT_W_DEF     = 16;
endpackage

// File: rtl/fetch_sequencer_mem_wait_timer.sv
// fetch_sequencer_mem_wait_timer: counts memory wait cycles and flags the timeout cycle.
module fetch_sequencer_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic en,
  output logic expired
);
  logic [7:0] count;
  always_ff @(posedge clk or negedge clr)
    if (!clr) count <= '0;
    else if (restart) count <= '0;
    else if (en) count <= count + 8'd1;
  // count holds completed waits, so the MEM_TIMEOUT-th waiting cycle is the last one in S_MEM
  assign expired = en && (count == 8'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore FSM sequencing PC/MAR/IR strobes through fetch, execute and branch.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int COUNT_W     = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               run,
  input  logic               halt_req,
  input  logic               mem_ready,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic               pc_enable,
  output logic [31:0]        pc_load_value,
  output logic               pc_inc,
  output logic               mar_load,
  output logic               mem_read,
  output logic               ir_load,
  output logic               exec_start,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);
  logic [2:0] state_q, state_d;
  logic halt_pend, exec_first, expired, done;
  logic [31:0] tgt;
  logic [COUNT_W-1:0] cnt;
  assign done = (state_q == S_EXEC) && exec_done;
  fetch_sequencer_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk),
    .clr(clr),
    .restart(state_q == S_ADDR),
    .en((state_q == S_MEM) && !mem_ready),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = run ? S_ADDR : S_IDLE;
      S_ADDR:   state_d = S_MEM;
      S_MEM:    state_d = mem_ready ? S_IR : expired ? S_FAULT : S_MEM;
      S_IR:     state_d = S_EXEC;
      S_EXEC:   state_d = !exec_done ? S_EXEC : branch_taken ? S_BRANCH :
                          (halt_pend || halt_req) ? S_HALT : run ? S_ADDR : S_IDLE;
      S_BRANCH: state_d = halt_pend ? S_HALT : run ? S_ADDR : S_IDLE;
      S_HALT:   state_d = (run && !halt_req) ? S_ADDR : S_HALT;
      default:  state_d = S_FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q    <= S_IDLE;
      halt_pend  <= 1'b0;
      exec_first <= 1'b0;
      tgt        <= '0;
      cnt        <= '0;
    end else begin
      state_q    <= state_d;
      exec_first <= state_q == S_IR;
      halt_pend  <= (state_d == S_HALT) ? 1'b0 :
                    (halt_req && !(state_q inside {S_IDLE, S_HALT, S_FAULT})) ? 1'b1 : halt_pend;
      if (done && branch_taken) tgt <= branch_target;
      if (done) cnt <= cnt + COUNT_W'(1);
    end
  assign pc_enable     = state_q == S_BRANCH;
  assign pc_load_value = tgt;
  assign pc_inc        = state_q == S_IR;
  assign mar_load      = state_q == S_ADDR;
  assign mem_read      = state_q == S_MEM;
  assign ir_load       = state_q == S_IR;
  assign exec_start    = exec_first;
  assign halted        = state_q == S_HALT;
  assign fault         = state_q == S_FAULT;
  assign state         = state_q;
  assign instr_count   = cnt;
endmodule
